// File: rtl/dcache_axi_responder_pkg.sv
// rtl/dcache_axi_responder_pkg.sv - shared types and AXI/cache-port encodings for the dcache responder
package dcache_axi_responder_pkg;

  typedef enum logic [2:0] {IDLE, AR, R, AW, B, DONE} state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  localparam logic [1:0] MEM_SIZE_1B = 2'd0;
  localparam logic [1:0] MEM_SIZE_2B = 2'd1;
  localparam logic [1:0] MEM_SIZE_4B = 2'd2;

  // The reserved cache-port code 3 is treated as a full word.
  function automatic logic [2:0] axi_size(input logic [1:0] mem_size);
    case (mem_size)
      MEM_SIZE_1B: axi_size = 3'b000;
      MEM_SIZE_2B: axi_size = 3'b001;
      MEM_SIZE_4B: axi_size = SIZE_4B;
      default:     axi_size = SIZE_4B;
    endcase
  endfunction

endpackage

// File: rtl/dcache_rline_asm.sv
// rtl/dcache_rline_asm.sv - beat counter plus line register that assembles read beats into a cache line
module dcache_rline_asm #(
  parameter int offset_width = 2
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             clr,
  input  logic                             we,
  input  logic                             suc,
  input  logic [31:0]                      wdata,
  output logic [32*(1<<offset_width)-1:0]  line
);

  localparam int WORDS = 1 << offset_width;
  localparam logic [offset_width-1:0] LAST = offset_width'(WORDS - 1);

  logic [offset_width-1:0] cnt_q, cnt_d;
  logic [32*WORDS-1:0]     line_q, line_d;
  logic [offset_width-1:0] slot;

  // Counter saturates on the last slot so overlong bursts keep overwriting it.
  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    slot   = suc ? '0 : cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (we) begin
      line_d[{slot, 5'd0} +: 32] = wdata;
      if (cnt_q != LAST) cnt_d = cnt_q + offset_width'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/dcache_axi_responder.sv
// rtl/dcache_axi_responder.sv - translates single data-cache requests into AXI4 line reads, single reads and stores
module dcache_axi_responder
  import dcache_axi_responder_pkg::*;
#(
  parameter int offset_width = 2,
  parameter int addr_width   = 32
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             dcache_mem_req,
  input  logic                             dcache_mem_wr,
  input  logic                             dcache_mem_SUC,
  input  logic [1:0]                       dcache_mem_size,
  input  logic [3:0]                       dcache_mem_wstrb,
  input  logic [addr_width-1:0]            addr_dcache_mem,
  input  logic [31:0]                      dout_dcache_mem,
  output logic                             mem_dcache_addrOK,
  output logic                             mem_dcache_dataOK,
  output logic [32*(1<<offset_width)-1:0]  din_mem_dcache,
  output logic [addr_width-1:0]            araddr,
  output logic [7:0]                       arlen,
  output logic [2:0]                       arsize,
  output logic [1:0]                       arburst,
  output logic                             arvalid,
  input  logic                             arready,
  input  logic [31:0]                      rdata,
  input  logic                             rlast,
  input  logic                             rvalid,
  output logic                             rready,
  output logic [addr_width-1:0]            awaddr,
  output logic [7:0]                       awlen,
  output logic [2:0]                       awsize,
  output logic [1:0]                       awburst,
  output logic                             awvalid,
  input  logic                             awready,
  output logic [31:0]                      wdata,
  output logic [3:0]                       wstrb,
  output logic                             wlast,
  output logic                             wvalid,
  input  logic                             wready,
  input  logic                             bvalid,
  output logic                             bready
);

  localparam logic [7:0] LINE_LEN = 8'((1 << offset_width) - 1);

  state_e                  state_q, state_d;
  logic [addr_width-1:0]   addr_q, addr_d;
  logic                    suc_q, suc_d;
  logic [1:0]              size_q, size_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [31:0]             data_q, data_d;
  logic                    addr_ok_q, addr_ok_d, data_ok_q, data_ok_d;
  logic                    arvalid_q, arvalid_d, rready_q, rready_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    beat_clr, beat_we;

  assign beat_clr = (state_q == AR) && arvalid_q && arready;
  assign beat_we  = (state_q == R) && rready_q && rvalid;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    suc_d     = suc_q;
    size_d    = size_q;
    wstrb_d   = wstrb_q;
    data_d    = data_q;
    addr_ok_d = 1'b0;
    data_ok_d = 1'b0;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    case (state_q)
      IDLE: if (dcache_mem_req) begin
        addr_d    = addr_dcache_mem;
        suc_d     = dcache_mem_SUC;
        size_d    = dcache_mem_size;
        wstrb_d   = dcache_mem_wstrb;
        data_d    = dout_dcache_mem;
        addr_ok_d = 1'b1;
        if (dcache_mem_wr) begin
          state_d   = AW;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          state_d   = AR;
          arvalid_d = 1'b1;
        end
      end
      AR: if (arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = R;
      end
      R: if (rvalid && rlast) begin
        rready_d  = 1'b0;
        data_ok_d = 1'b1;
        state_d   = DONE;
      end
      // Address and data channels handshake independently, possibly together.
      AW: begin
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = B;
        end
      end
      B: if (bvalid) begin
        bready_d  = 1'b0;
        data_ok_d = 1'b1;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      suc_q     <= 1'b0;
      size_q    <= '0;
      wstrb_q   <= '0;
      data_q    <= '0;
      addr_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      suc_q     <= suc_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      data_q    <= data_d;
      addr_ok_q <= addr_ok_d;
      data_ok_q <= data_ok_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
    end
  end

  dcache_rline_asm #(.offset_width(offset_width)) u_rline (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (beat_clr),
    .we    (beat_we),
    .suc   (suc_q),
    .wdata (rdata),
    .line  (din_mem_dcache)
  );

  assign mem_dcache_addrOK = addr_ok_q;
  assign mem_dcache_dataOK = data_ok_q;
  assign araddr  = addr_q;
  assign arlen   = suc_q ? 8'd0 : LINE_LEN;
  assign arsize  = suc_q ? axi_size(size_q) : SIZE_4B;
  assign arburst = BURST_INCR;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = axi_size(size_q);
  assign awburst = BURST_INCR;
  assign awvalid = awvalid_q;
  assign wdata   = data_q;
  assign wstrb   = wstrb_q;
  assign wlast   = wvalid_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: tb/tb_dcache_axi_responder.sv
// tb/tb_dcache_axi_responder.sv - directed self-checking bench for dcache_axi_responder
module tb_dcache_axi_responder;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req, wr, suc;
  logic [1:0]   size;
  logic [3:0]   mwstrb;
  logic [31:0]  addr, dout;
  logic         addr_ok, data_ok;
  logic [127:0] din;
  logic [31:0]  araddr, awaddr, wdata, rdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]   wstrb;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int addrok_cnt = 0;
  int ar_cnt = 0;
  int a0, r0;

  dcache_axi_responder #(.offset_width(2), .addr_width(32)) dut (
    .clk(clk), .rstn(rstn),
    .dcache_mem_req(req), .dcache_mem_wr(wr), .dcache_mem_SUC(suc),
    .dcache_mem_size(size), .dcache_mem_wstrb(mwstrb),
    .addr_dcache_mem(addr), .dout_dcache_mem(dout),
    .mem_dcache_addrOK(addr_ok), .mem_dcache_dataOK(data_ok), .din_mem_dcache(din),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rstn) begin
      if (addr_ok) addrok_cnt <= addrok_cnt + 1;
      if (arvalid && arready) ar_cnt <= ar_cnt + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; req = 1'b0; wr = 1'b0; suc = 1'b0; size = 2'd2; mwstrb = 4'h0;
    addr = 32'h0; dout = 32'h0; arready = 1'b0; rdata = 32'h0; rlast = 1'b0;
    rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    tick; tick;
    chk("rst_addrok", 128'(addr_ok), 128'd0);
    chk("rst_dataok", 128'(data_ok), 128'd0);
    chk("rst_valids", 128'({arvalid, rready, awvalid, wvalid, bready, wlast}), 128'd0);
    chk("rst_din", din, 128'd0);
    rstn = 1'b1;
    tick;

    // cached line read
    req = 1'b1; wr = 1'b0; suc = 1'b0; size = 2'd2; addr = 32'h1C000040; arready = 1'b1;
    tick;
    chk("t1_addrok", 128'(addr_ok), 128'd1);
    chk("t1_arvalid", 128'(arvalid), 128'd1);
    chk("t1_araddr", 128'(araddr), 128'h1C000040);
    chk("t1_arlen", 128'(arlen), 128'd3);
    chk("t1_arsize", 128'(arsize), 128'd2);
    chk("t1_arburst", 128'(arburst), 128'd1);
    req = 1'b0;
    tick;
    chk("t1_addrok_pulse", 128'(addr_ok), 128'd0);
    chk("t1_ar_drop", 128'(arvalid), 128'd0);
    chk("t1_rready", 128'(rready), 128'd1);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h11111111;
    tick; rdata = 32'h22222222;
    tick; rdata = 32'h33333333;
    tick;
    chk("t1_no_early_dataok", 128'(data_ok), 128'd0);
    rdata = 32'h44444444; rlast = 1'b1;
    tick;
    chk("t1_dataok", 128'(data_ok), 128'd1);
    chk("t1_line", din, 128'h44444444_33333333_22222222_11111111);
    rvalid = 1'b0; rlast = 1'b0;
    tick;
    chk("t1_dataok_pulse", 128'(data_ok), 128'd0);
    chk("t1_rready_off", 128'(rready), 128'd0);

    // uncached byte read
    req = 1'b1; suc = 1'b1; size = 2'd0; addr = 32'hBFD003F8;
    tick;
    chk("t2_addrok", 128'(addr_ok), 128'd1);
    chk("t2_arlen", 128'(arlen), 128'd0);
    chk("t2_arsize", 128'(arsize), 128'd0);
    chk("t2_araddr", 128'(araddr), 128'hBFD003F8);
    req = 1'b0; arready = 1'b1;
    tick;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h000000A5; rlast = 1'b1;
    tick;
    chk("t2_dataok", 128'(data_ok), 128'd1);
    chk("t2_line", din, 128'h44444444_33333333_22222222_000000A5);
    rvalid = 1'b0; rlast = 1'b0;
    tick;
    chk("t2_dataok_pulse", 128'(data_ok), 128'd0);

    // store with late wready
    req = 1'b1; wr = 1'b1; suc = 1'b0; size = 2'd0; addr = 32'h1C000104;
    mwstrb = 4'b0100; dout = 32'h00AB0000;
    tick;
    chk("t3_addrok", 128'(addr_ok), 128'd1);
    chk("t3_vld", 128'({awvalid, wvalid, wlast}), 128'b111);
    chk("t3_awaddr", 128'(awaddr), 128'h1C000104);
    chk("t3_awfields", 128'({awlen, awsize, awburst}), 128'({8'd0, 3'd0, 2'd1}));
    chk("t3_wdata", 128'(wdata), 128'h00AB0000);
    chk("t3_wstrb", 128'(wstrb), 128'b0100);
    req = 1'b0; wr = 1'b0; awready = 1'b1;
    tick;
    chk("t3_aw_drop", 128'({awvalid, wvalid}), 128'b01);
    awready = 1'b0;
    tick;
    chk("t3_w_held", 128'({wvalid, wlast, bready}), 128'b110);
    wready = 1'b1;
    tick;
    chk("t3_w_drop", 128'({wvalid, bready}), 128'b01);
    wready = 1'b0;
    tick;
    chk("t3_wait_b", 128'({bready, data_ok}), 128'b10);
    bvalid = 1'b1;
    tick;
    chk("t3_dataok", 128'({data_ok, bready}), 128'b10);
    chk("t3_din_kept", din, 128'h44444444_33333333_22222222_000000A5);
    bvalid = 1'b0;
    tick;
    chk("t3_dataok_pulse", 128'(data_ok), 128'd0);

    // AR backpressure and gapped beats
    req = 1'b1; size = 2'd2; addr = 32'h1C000080;
    tick;
    chk("t4_addrok", 128'(addr_ok), 128'd1);
    req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t4_ar_stable", 128'({arvalid, araddr}), 128'({1'b1, 32'h1C000080}));
    end
    arready = 1'b1;
    tick;
    arready = 1'b0;
    chk("t4_rready", 128'({arvalid, rready}), 128'b01);
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b0;
      tick; tick;
      chk("t4_gap_no_dataok", 128'(data_ok), 128'd0);
      rvalid = 1'b1; rdata = 32'hA0000000 + 32'(k); rlast = (k == 3);
      tick;
      if (k == 1) chk("t4_partial", din, 128'h44444444_33333333_A0000001_A0000000);
    end
    chk("t4_dataok", 128'(data_ok), 128'd1);
    chk("t4_line", din, 128'hA0000003_A0000002_A0000001_A0000000);
    rvalid = 1'b0; rlast = 1'b0;
    tick;

    // req held after addrOK
    a0 = addrok_cnt; r0 = ar_cnt;
    req = 1'b1; addr = 32'h1C0000C0; arready = 1'b1;
    tick;
    chk("t5_addrok", 128'(addr_ok), 128'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t5_no_reaccept", 128'({addr_ok, arvalid}), 128'b00);
    end
    req = 1'b0; arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1; rdata = 32'hC0 + 32'(k); rlast = (k == 3);
      tick;
    end
    chk("t5_line", din, 128'h000000C3_000000C2_000000C1_000000C0);
    rvalid = 1'b0; rlast = 1'b0;
    tick; tick;
    chk("t5_one_addrok", 128'(addrok_cnt - a0), 128'd1);
    chk("t5_one_ar", 128'(ar_cnt - r0), 128'd1);

    // reset in the middle of a burst
    req = 1'b1; addr = 32'h1C000100; arready = 1'b1;
    tick;
    req = 1'b0;
    tick;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h55555555;
    tick; rdata = 32'h66666666;
    tick;
    rvalid = 1'b0;
    chk("t6_partial", din, 128'h000000C3_000000C2_66666666_55555555);
    #1 rstn = 1'b0;
    #1;
    chk("t6_rst_rready", 128'({rready, arvalid, addr_ok}), 128'd0);
    chk("t6_rst_dataok", 128'(data_ok), 128'd0);
    chk("t6_rst_din", din, 128'd0);
    tick;
    rstn = 1'b1;
    tick;
    req = 1'b1; addr = 32'h1C000140; arready = 1'b1;
    tick;
    chk("t6_fresh_ar", 128'({addr_ok, arvalid, araddr}), 128'({2'b11, 32'h1C000140}));
    req = 1'b0;
    tick;
    arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1; rdata = 32'h70000000 + 32'(k); rlast = (k == 3);
      tick;
    end
    chk("t6_fresh_dataok", 128'(data_ok), 128'd1);
    chk("t6_fresh_line", din, 128'h70000003_70000002_70000001_70000000);
    rvalid = 1'b0; rlast = 1'b0;
    tick;
    chk("t6_idle", 128'({data_ok, rready}), 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
